cdc_stable_capture: RTL and testbench

Downstream consumer of the per-bit two-flop synchronizer, in the destination (`clk_out`) domain. Per-bit synchronization does not keep a multi-bit bus coherent, so this block qualifies each value first. A value counts only after it has been sampled unchanged on `STABLE_CYCLES` consecutive edges. Each newly qualified value that differs from the last one accepted is pushed once into a small first-word-fall-through (FWFT) FIFO, which downstream logic drains through a valid/ready handshake.

---
 rtl/cdc_stable_capture_if.sv | 35 +++
 rtl/cdc_stable_capture.sv | 167 ++++++++++++++++
 tb/tb_cdc_stable_capture.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_stable_capture_if.sv
// -----------------------------------------------------------------------------
// cdc_stable_capture_if
//
// Output stream of cdc_stable_capture: the head FIFO entry offered to a
// downstream consumer through a valid/ready handshake.
//
//   out_data  : head FIFO entry, meaningful while out_valid is high
//   out_valid : FIFO holds at least one entry
//   out_ready : consumer accepts the head entry on this edge
//
// Modports:
//   master : the capture block (drives data/valid, observes ready)
//   slave  : the consumer      (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface cdc_stable_capture_if #(
    parameter int N = 8
);

    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface : cdc_stable_capture_if

// File: rtl/cdc_stable_capture.sv
// -----------------------------------------------------------------------------
// cdc_stable_capture
//
// Destination-domain consumer of a per-bit two-flop synchronizer. Bits of a
// bus synchronized independently may land on different edges, so a value is
// trusted only once it has been sampled unchanged on STABLE_CYCLES
// consecutive edges. Every qualified value that differs from the last one
// accepted is pushed once into a first-word-fall-through FIFO, drained by the
// consumer through a valid/ready handshake.
//
// Parameters:
//   N             : data bus width
//   STABLE_CYCLES : consecutive equal samples needed to qualify (2..15)
//   DEPTH         : FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk_out   : destination clock, all logic on its rising edge
//   rst_out_n : asynchronous active-low reset, clears every register
//   sync_data : synchronized bus
//   sync_rst  : synchronized active-high clear (flushes FIFO, restarts
//               qualification, clears overflow)
//   stream    : out_data / out_valid / out_ready handshake (master side)
//   stable    : the current input run has qualified
//   overflow  : sticky, a qualified value was dropped on a full FIFO
//   level     : FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module cdc_stable_capture #(
    parameter int N             = 8,
    parameter int STABLE_CYCLES = 3,
    parameter int DEPTH         = 4
) (
    input  logic                     clk_out,
    input  logic                     rst_out_n,
    input  logic [N-1:0]             sync_data,
    input  logic                     sync_rst,
    cdc_stable_capture_if.master     stream,
    output logic                     stable,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    // ------------------------------------------------------------------
    // Qualifier state
    // ------------------------------------------------------------------
    logic [N-1:0]     s;           // previous sample of sync_data
    logic [RUN_W-1:0] run;         // length of the current equal run, saturating
    logic [N-1:0]     held;        // last value accepted for pushing
    logic             held_valid;  // held contains a real value

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [N-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic same;      // this edge's sample matches the previous one
    logic qualify;   // run completes on this edge with a new value
    logic full;
    logic pop;
    logic push;      // qualified value actually written
    logic drop;      // qualified value lost to a full FIFO

    assign same    = (sync_data == s);
    // Run reaches STABLE_CYCLES on this edge; saturation makes this true at
    // most once per run, and comparing against held suppresses a value that
    // merely re-qualifies after an unqualified glitch.
    assign qualify = !sync_rst && (run == RUN_PRE) && same &&
                     (!held_valid || (sync_data != held));

    assign full    = (level == LVL_MAX);
    assign pop     = !sync_rst && stream.out_valid && stream.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push    = qualify && (!full || pop);
    assign drop    = qualify && full && !pop;

    assign stable           = (run == RUN_MAX);
    assign stream.out_valid = (level != '0);
    assign stream.out_data  = mem[rd_ptr];

    // ------------------------------------------------------------------
    // Qualifier
    // ------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge value of its neighbours (s, run, held are
    // compared against each other within the same edge).
    always_ff @(posedge clk_out or negedge rst_out_n) begin
        if (!rst_out_n) begin
            s          <= '0;
            run        <= '0;
            held       <= '0;
            held_valid <= 1'b0;
        end else begin
            // s loads even during sync_rst so the first post-clear compare
            // is against a real sample.
            s <= sync_data;
            if (sync_rst) begin
                run        <= '0;
                held_valid <= 1'b0;
            end else begin
                if (run == '0 || !same) begin
                    run <= RUN_W'(1);
                end else if (run != RUN_MAX) begin
                    run <= run + RUN_W'(1);
                end
                // held tracks every qualified value, including ones
                // dropped on overflow; a lost event is not retried.
                if (qualify) begin
                    held       <= sync_data;
                    held_valid <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    // NOTE: the storage array is included in the asynchronous reset so
    // out_data reads as zero straight out of reset instead of X.
    always_ff @(posedge clk_out or negedge rst_out_n) begin
        if (!rst_out_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (sync_rst) begin
            // Flush only; stored words are left in place and become
            // unreachable once the pointers meet.
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sync_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule : cdc_stable_capture

// File: tb/tb_cdc_stable_capture.sv
// -----------------------------------------------------------------------------
// tb_cdc_stable_capture
//
// Directed bench for cdc_stable_capture (N=8, STABLE_CYCLES=3, DEPTH=4).
// Stimulus changes 1 time unit after each rising edge. Every value the bench
// expects to be pushed is appended to a scoreboard queue; a monitor on the
// falling edge pops and compares whenever out_valid and out_ready are both
// high, i.e. whenever the next rising edge will consume the head entry.
// Status outputs (level, stable, overflow, out_valid) are checked directly
// by the stimulus process against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cdc_stable_capture;

    localparam int N = 8;

    logic         clk_out;
    logic         rst_out_n;
    logic [N-1:0] sync_data;
    logic         sync_rst;
    logic         stable;
    logic         overflow;
    logic [2:0]   level;

    cdc_stable_capture_if #(.N(N)) stream_if ();

    cdc_stable_capture #(
        .N             (N),
        .STABLE_CYCLES (3),
        .DEPTH         (4)
    ) dut (
        .clk_out   (clk_out),
        .rst_out_n (rst_out_n),
        .sync_data (sync_data),
        .sync_rst  (sync_rst),
        .stream    (stream_if),
        .stable    (stable),
        .overflow  (overflow),
        .level     (level)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] sb [$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance n rising edges; inputs may be changed right after return.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_out);
            #1;
        end
    endtask

    // Monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk_out) begin
        if (rst_out_n && !sync_rst && stream_if.out_valid && stream_if.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %0h, expected no entry (t=%0t)",
                         stream_if.out_data, $time);
            end else begin
                check("pop_data", {24'h0, stream_if.out_data}, {24'h0, sb[0]});
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_out_n           = 1'b0;
        sync_data           = 8'h5A;
        sync_rst            = 1'b0;
        stream_if.out_ready = 1'b0;

        // ---------------- reset values ----------------
        #2;
        check("rst_valid",    32'(stream_if.out_valid), 32'd0);
        check("rst_data",     32'(stream_if.out_data),  32'h0);
        check("rst_stable",   32'(stable),              32'd0);
        check("rst_overflow", 32'(overflow),            32'd0);
        check("rst_level",    32'(level),               32'd0);
        @(posedge clk_out);
        #1;
        rst_out_n = 1'b1;

        // ---------------- 1: basic qualification ----------------
        step();
        check("t1_valid_e0",  32'(stream_if.out_valid), 32'd0);
        check("t1_stable_e0", 32'(stable),              32'd0);
        step();
        check("t1_valid_e1",  32'(stream_if.out_valid), 32'd0);
        sb.push_back(8'h5A);
        step();
        check("t1_valid_e2",  32'(stream_if.out_valid), 32'd1);
        check("t1_data",      32'(stream_if.out_data),  32'h5A);
        check("t1_level",     32'(level),               32'd1);
        check("t1_stable",    32'(stable),              32'd1);
        step(20);
        check("t1_no_repush", 32'(level),               32'd1);
        stream_if.out_ready = 1'b1;
        step();
        check("t1_drained",   32'(stream_if.out_valid), 32'd0);
        stream_if.out_ready = 1'b0;

        // ---------------- 2: glitch rejection ----------------
        sync_data = 8'h11;
        step();
        check("t2_stable_drop", 32'(stable), 32'd0);
        step();
        sync_data = 8'h3C;
        step();
        sync_data = 8'h11;
        step(2);
        check("t2_not_yet",  32'(stream_if.out_valid), 32'd0);
        sb.push_back(8'h11);
        step();
        check("t2_valid",    32'(stream_if.out_valid), 32'd1);
        check("t2_data",     32'(stream_if.out_data),  32'h11);
        step(20);
        check("t2_one_entry", 32'(level), 32'd1);
        stream_if.out_ready = 1'b1;
        step();
        check("t2_drained",  32'(stream_if.out_valid), 32'd0);
        stream_if.out_ready = 1'b0;

        // ---------------- 3: fill, overflow, drain ----------------
        for (int v = 1; v <= 4; v++) begin
            sync_data = 8'(v);
            sb.push_back(8'(v));
            step(3);
        end
        check("t3_full_level",   32'(level),    32'd4);
        check("t3_no_overflow",  32'(overflow), 32'd0);
        sync_data = 8'h05;
        step(3);
        check("t3_overflow",     32'(overflow), 32'd1);
        check("t3_level_stays",  32'(level),    32'd4);
        stream_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_drain_level", 32'(level), 32'(3 - i));
        end
        check("t3_valid_low",    32'(stream_if.out_valid), 32'd0);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        stream_if.out_ready = 1'b0;

        // sync_rst clears the sticky flag
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_level",    32'(level),    32'd0);

        // ---------------- 4: full with simultaneous push/pop ----------------
        for (int v = 8'h21; v <= 8'h24; v++) begin
            sync_data = 8'(v);
            sb.push_back(8'(v));
            step(3);
        end
        check("t4_full", 32'(level), 32'd4);
        sync_data = 8'hAA;
        step(2);
        sb.push_back(8'hAA);
        stream_if.out_ready = 1'b1;
        step();
        check("t4_level_stays",    32'(level),    32'd4);
        check("t4_overflow_stays", 32'(overflow), 32'd0);
        step(3);
        check("t4_last_level", 32'(level),               32'd1);
        check("t4_aa_head",    32'(stream_if.out_data),  32'hAA);
        step();
        check("t4_empty",      32'(stream_if.out_valid), 32'd0);
        stream_if.out_ready = 1'b0;

        // ---------------- 5: sync_rst mid-operation ----------------
        sync_data = 8'h31;
        sb.push_back(8'h31);
        step(3);
        sync_data = 8'h32;
        sb.push_back(8'h32);
        step(3);
        check("t5_level2", 32'(level), 32'd2);
        sync_data = 8'h33;
        step();
        sync_data = 8'h32;
        step(2);                              // run of 32 is now 2
        sync_rst = 1'b1;
        step();
        sync_rst = 1'b0;
        sb.delete();
        check("t5_level",    32'(level),               32'd0);
        check("t5_valid",    32'(stream_if.out_valid), 32'd0);
        check("t5_overflow", 32'(overflow),            32'd0);
        check("t5_stable",   32'(stable),              32'd0);
        step();
        check("t5_wait1",    32'(stream_if.out_valid), 32'd0);
        step();
        check("t5_wait2",    32'(stream_if.out_valid), 32'd0);
        sb.push_back(8'h32);
        step();
        check("t5_repush",   32'(stream_if.out_valid), 32'd1);
        check("t5_data",     32'(stream_if.out_data),  32'h32);
        check("t5_level1",   32'(level),               32'd1);
        stream_if.out_ready = 1'b1;
        step();
        check("t5_drained",  32'(stream_if.out_valid), 32'd0);
        stream_if.out_ready = 1'b0;

        // ---------------- 6: asynchronous reset ----------------
        sync_data = 8'h41;
        sb.push_back(8'h41);
        step(3);
        check("t6_pre_valid",  32'(stream_if.out_valid), 32'd1);
        check("t6_pre_stable", 32'(stable),              32'd1);
        #2;
        rst_out_n = 1'b0;
        #1;
        sb.delete();
        check("t6_valid",    32'(stream_if.out_valid), 32'd0);
        check("t6_data",     32'(stream_if.out_data),  32'h0);
        check("t6_stable",   32'(stable),              32'd0);
        check("t6_overflow", 32'(overflow),            32'd0);
        check("t6_level",    32'(level),               32'd0);
        @(posedge clk_out);
        #1;
        rst_out_n = 1'b1;
        step(2);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cdc_stable_capture
